// File: rtl/alu_issue_stage_pkg.sv
// Shared types and constants for the ALU issue stage.
// Instruction layout, opcode map and FSM state encoding.
package alu_issue_stage_pkg;

  localparam int DATA_W = 16;
  localparam int RA_W   = 3;
  localparam int INSTR_W = 16;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;
  localparam int RD_HI  = 10;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 5;
  localparam int RS2_HI = 4;
  localparam int RS2_LO = 2;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [4:0] OP_ADD       = 5'b00001;
  localparam logic [4:0] OP_SUB       = 5'b00010;
  localparam logic [4:0] OP_ALU_LAST  = 5'b00111;
  localparam logic [4:0] OP_CMP       = 5'b01000;
  localparam logic [4:0] OP_CMP_LAST  = 5'b01010;
  localparam logic [4:0] OP_MOV       = 5'b01011;
  localparam logic [4:0] OP_LDI       = 5'b11000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_RETIRE
  } state_e;

  typedef enum logic [1:0] {
    K_ALU,
    K_CMP,
    K_LDI,
    K_ILL
  } op_kind_e;

  function automatic op_kind_e op_kind(
    input logic [4:0] op
  );
    op_kind_e k;
    k = K_ILL;
    unique case (1'b1)
      (op <= OP_ALU_LAST) || (op == OP_MOV):
        k = K_ALU;
      (op >= OP_CMP) && (op <= OP_CMP_LAST):
        k = K_CMP;
      (op == OP_LDI):
        k = K_LDI;
      default:
        k = K_ILL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction handshake plus the bus to the external ALU.
// The stage is the slave of the instruction stream.
interface alu_issue_stage_if;
  import alu_issue_stage_pkg::*;

  logic                  instr_valid;
  logic                  instr_ready;
  logic [INSTR_W-1:0]    instr;
  logic                  alu_enable;
  logic [4:0]            alu_op;
  logic [DATA_W-1:0]     alu_a;
  logic [DATA_W-1:0]     alu_b;
  logic [DATA_W-1:0]     alu_result;

  modport master (
    output instr_valid,
    output instr,
    output alu_result,
    input  instr_ready,
    input  alu_enable,
    input  alu_op,
    input  alu_a,
    input  alu_b
  );

  modport slave (
    input  instr_valid,
    input  instr,
    input  alu_result,
    output instr_ready,
    output alu_enable,
    output alu_op,
    output alu_a,
    output alu_b
  );

endinterface

// File: rtl/issue_regfile.sv
// 8x16 register file, r0 hardwired to zero.
// Two operand read ports, one debug read port, one sync write.
module issue_regfile #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RA_W-1:0]   ra1,
  input  logic [RA_W-1:0]   ra2,
  input  logic [RA_W-1:0]   rad,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rdd,
  input  logic              we,
  input  logic [RA_W-1:0]   wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int NREG = 1 << RA_W;

  logic [DATA_W-1:0] mem [1:NREG-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NREG; i++)
        mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    rdd = '0;
    if (ra1 != '0) rd1 = mem[ra1];
    if (ra2 != '0) rd2 = mem[ra2];
    if (rad != '0) rdd = mem[rad];
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Four-state issue stage feeding an external combinational ALU.
// Accept, read operands, execute, retire: one instr per 4 cycles.
module alu_issue_stage #(
  parameter int DATA_W = alu_issue_stage_pkg::DATA_W,
  parameter int RA_W   = alu_issue_stage_pkg::RA_W
) (
  input  logic              clk,
  input  logic              reset,
  alu_issue_stage_if.slave  bus,
  output logic              done,
  output logic              flag_z,
  output logic              flag_n,
  output logic              illegal,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  import alu_issue_stage_pkg::*;

  state_e              state_q;
  state_e              state_d;
  logic [INSTR_W-1:0]  ir_q;
  logic [DATA_W-1:0]   opa_q;
  logic [DATA_W-1:0]   opb_q;
  logic [DATA_W-1:0]   rs1_val;
  logic [DATA_W-1:0]   rs2_val;
  logic                rf_we;
  logic [DATA_W-1:0]   rf_wd;
  logic [4:0]          opcode;
  logic [RA_W-1:0]     rd;
  logic [RA_W-1:0]     rs1;
  logic [RA_W-1:0]     rs2;
  logic [7:0]          imm8;
  op_kind_e            kind;
  logic                upd_flags;

  assign opcode = ir_q[OPC_HI:OPC_LO];
  assign rd     = ir_q[RD_HI:RD_LO];
  assign rs1    = ir_q[RS1_HI:RS1_LO];
  assign rs2    = ir_q[RS2_HI:RS2_LO];
  assign imm8   = ir_q[IMM_HI:IMM_LO];
  assign kind   = op_kind(opcode);

  assign upd_flags = (state_q == S_EXEC)
                  && ((kind == K_ALU) || (kind == K_CMP));

  // Write lands on the EXEC->RETIRE edge so the next READ sees it.
  assign rf_we = (state_q == S_EXEC)
              && ((kind == K_ALU) || (kind == K_LDI));
  assign rf_wd = (kind == K_LDI)
               ? {{(DATA_W-8){1'b0}}, imm8}
               : bus.alu_result;

  issue_regfile #(
    .DATA_W (DATA_W),
    .RA_W   (RA_W)
  ) u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs1),
    .ra2   (rs2),
    .rad   (dbg_addr),
    .rd1   (rs1_val),
    .rd2   (rs2_val),
    .rdd   (dbg_data),
    .we    (rf_we),
    .wa    (rd),
    .wd    (rf_wd)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.instr_valid) state_d = S_READ;
      S_READ:   state_d = S_EXEC;
      S_EXEC:   state_d = S_RETIRE;
      S_RETIRE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q   <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && bus.instr_valid)
        ir_q <= bus.instr;
      if (state_q == S_READ) begin
        opa_q <= rs1_val;
        opb_q <= rs2_val;
      end
      if (upd_flags) begin
        flag_z <= (bus.alu_result == '0);
        flag_n <= bus.alu_result[DATA_W-1];
      end
    end
  end

  always_comb begin
    bus.instr_ready = 1'b0;
    bus.alu_enable  = 1'b0;
    bus.alu_op      = '0;
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    done            = 1'b0;
    illegal         = 1'b0;
    unique case (state_q)
      S_IDLE: bus.instr_ready = 1'b1;
      S_EXEC: begin
        bus.alu_enable = (kind == K_ALU)
                      || (kind == K_CMP);
        bus.alu_op     = opcode;
        bus.alu_a      = opa_q;
        bus.alu_b      = opb_q;
      end
      S_RETIRE: begin
        done    = 1'b1;
        illegal = (kind == K_ILL);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vectors plus random
// instructions checked against an architectural register model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        done;
  logic        flag_z;
  logic        flag_n;
  logic        illegal;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] mr [8];
  logic        mz;
  logic        mn;

  always #5 clk = ~clk;

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .done     (done),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .illegal  (illegal),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Reference ALU; anything not listed passes operand A.
  function automatic logic [15:0] alu_ref(
    input logic [4:0]  op,
    input logic [15:0] a,
    input logic [15:0] b
  );
    case (op)
      5'd1:        return a + b;
      5'd2, 5'd8:  return a - b;
      5'd3, 5'd9:  return a & b;
      5'd4:        return a | b;
      5'd5, 5'd10: return a ^ b;
      5'd6:        return a << b[3:0];
      5'd7:        return a >> b[3:0];
      default:     return a;
    endcase
  endfunction

  assign bus.alu_result = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);

  function automatic logic [15:0] enc(
    input int op, input int rd, input int s1, input int s2
  );
    logic [4:0] o;
    logic [2:0] d, a, b;
    o = op[4:0]; d = rd[2:0]; a = s1[2:0]; b = s2[2:0];
    return {o, d, a, b, 2'b00};
  endfunction

  function automatic logic [15:0] ldi(input int rd, input int imm);
    logic [2:0] d;
    logic [7:0] i;
    d = rd[2:0]; i = imm[7:0];
    return {5'b11000, d, i};
  endfunction

  task automatic chk(
    input string tag, input logic [31:0] obs, input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input int idx, input logic [15:0] exp);
    dbg_addr = idx[2:0];
    #1;
    chk(tag, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mr[i] = 16'h0;
    mz = 1'b0;
    mn = 1'b0;
  endtask

  // Called at a sample point in IDLE; returns at the next IDLE sample point.
  task automatic exec_one(input logic [15:0] w);
    logic [4:0]  op;
    int          rd, s1, s2;
    logic [15:0] a, b, res;
    bit          is_alu, is_cmp, is_ldi, is_ill;
    int          n;
    op = w[15:11];
    rd = int'(w[10:8]); s1 = int'(w[7:5]); s2 = int'(w[4:2]);
    is_alu = (op <= 5'd7) || (op == 5'd11);
    is_cmp = (op >= 5'd8) && (op <= 5'd10);
    is_ldi = (op == 5'd24);
    is_ill = !(is_alu || is_cmp || is_ldi);
    a = mr[s1];
    b = mr[s2];
    bus.instr_valid = 1'b1;
    bus.instr = w;
    n = 0;
    while (!bus.instr_ready && n < 8) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_ready", {31'h0, bus.instr_ready}, 32'h1);
    @(posedge clk); #1;
    // Noise on the handshake outside IDLE must be ignored.
    bus.instr_valid = 1'($urandom);
    bus.instr = 16'($urandom);
    chk("read_ready", {31'h0, bus.instr_ready}, 32'h0);
    chk("read_done", {31'h0, done}, 32'h0);
    @(posedge clk); #1;
    chk("exec_en", {31'h0, bus.alu_enable}, {31'h0, is_alu || is_cmp});
    chk("exec_op", {27'h0, bus.alu_op}, {27'h0, op});
    chk("exec_a", {16'h0, bus.alu_a}, {16'h0, a});
    chk("exec_b", {16'h0, bus.alu_b}, {16'h0, b});
    res = alu_ref(op, a, b);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    chk("ret_done", {31'h0, done}, 32'h1);
    chk("ret_illegal", {31'h0, illegal}, {31'h0, is_ill});
    if (is_alu && rd != 0) mr[rd] = res;
    if (is_ldi && rd != 0) mr[rd] = {8'h00, w[7:0]};
    if (is_alu || is_cmp) begin
      mz = (res == 16'h0);
      mn = res[15];
    end
    chk("ret_z", {31'h0, flag_z}, {31'h0, mz});
    chk("ret_n", {31'h0, flag_n}, {31'h0, mn});
    chk_reg("ret_rd", rd, mr[rd]);
    n = $urandom_range(0, 7);
    chk_reg("ret_rand", n, mr[n]);
    @(posedge clk); #1;
    chk("idle_done", {31'h0, done}, 32'h0);
    chk("idle_illegal", {31'h0, illegal}, 32'h0);
    chk("idle_ready", {31'h0, bus.instr_ready}, 32'h1);
  endtask

  logic [4:0] op_tab [16];

  initial begin
    logic [15:0] w;
    logic [4:0]  rop;
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0;
    dbg_addr = 3'd0;
    model_reset();
    for (int i = 0; i < 12; i++) op_tab[i] = 5'(i);
    op_tab[12] = 5'b11000;
    op_tab[13] = 5'b10000;
    op_tab[14] = 5'b11111;
    op_tab[15] = 5'b01101;

    @(posedge clk); #1;
    chk("rst_ready", {31'h0, bus.instr_ready}, 32'h1);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_en", {31'h0, bus.alu_enable}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_illegal", {31'h0, illegal}, 32'h0);
    chk("rst_z", {31'h0, flag_z}, 32'h0);
    chk("rst_n", {31'h0, flag_n}, 32'h0);
    for (int i = 0; i < 8; i++) chk_reg("rst_reg", i, 16'h0);

    exec_one(ldi(1, 8'h05));
    exec_one(ldi(2, 8'h03));
    chk_reg("v_r1", 1, 16'h0005);
    chk_reg("v_r2", 2, 16'h0003);

    exec_one(enc(1, 3, 1, 2));
    chk_reg("v_add", 3, 16'h0008);
    chk("v_add_z", {31'h0, flag_z}, 32'h0);
    chk("v_add_n", {31'h0, flag_n}, 32'h0);
    exec_one(enc(2, 4, 2, 1));
    chk_reg("v_sub", 4, 16'hFFFE);
    chk("v_sub_n", {31'h0, flag_n}, 32'h1);

    exec_one(enc(8, 0, 1, 1));
    chk("v_cmp_z", {31'h0, flag_z}, 32'h1);

    exec_one({5'b10000, 11'h3A5});
    chk("v_ill_z", {31'h0, flag_z}, 32'h1);
    exec_one(ldi(0, 8'hFF));
    chk_reg("v_r0", 0, 16'h0000);

    // Continuous valid: accepts every 4th cycle, dependent ADDs.
    bus.instr_valid = 1'b1;
    bus.instr = enc(1, 5, 5, 1);
    for (int k = 0; k <= 8; k++) begin
      chk("bb_ready", {31'h0, bus.instr_ready},
          {31'h0, (k % 4) == 0});
      if (k == 3) chk_reg("bb_r5a", 5, 16'h0005);
      if (k == 7) chk_reg("bb_r5b", 5, 16'h000A);
      if (k == 8) bus.instr_valid = 1'b0;
      else begin
        @(posedge clk); #1;
      end
    end
    mr[5] = 16'h000A;
    mz = 1'b0;
    mn = 1'b0;
    chk("bb_z", {31'h0, flag_z}, 32'h0);

    for (int t = 0; t < 60; t++) begin
      rop = op_tab[$urandom_range(0, 15)];
      w = 16'($urandom);
      w[15:11] = rop;
      exec_one(w);
    end

    // Reset in EXEC aborts the instruction.
    bus.instr_valid = 1'b1;
    bus.instr = enc(1, 6, 1, 2);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("ab_exec_en", {31'h0, bus.alu_enable}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("ab_ready", {31'h0, bus.instr_ready}, 32'h1);
    chk("ab_done", {31'h0, done}, 32'h0);
    chk("ab_en", {31'h0, bus.alu_enable}, 32'h0);
    @(posedge clk); #1;
    chk("ab_done2", {31'h0, done}, 32'h0);
    chk("ab_z", {31'h0, flag_z}, 32'h0);
    chk("ab_n", {31'h0, flag_n}, 32'h0);
    model_reset();
    for (int i = 0; i < 8; i++) chk_reg("ab_reg", i, mr[i]);

    exec_one(ldi(7, 8'h80));
    exec_one(enc(6, 6, 7, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
